// File: rtl/neo_slot_pkg.sv
// Shared constants for the multi-slot cartridge controller.
// Holds the DTACK state machine encoding and the latched cycle type encoding.
package neo_slot_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_WAIT = 3'd1;
   localparam state_t ST_ACK  = 3'd2;
   localparam state_t ST_EXT  = 3'd3;
   localparam state_t ST_BERR = 3'd4;

   localparam logic CYC_ROM  = 1'b0;
   localparam logic CYC_PORT = 1'b1;

endpackage

// File: rtl/neo_slot_decode.sv
// Slot select decoder (purely combinational).
// Ports:
//   slot_sel     in   current slot register
//   enable       in   slot decode enable; low forces every select high
//   n_slot_cs    out  one-hot active-low slot selects
//   slot_invalid out  slot register points past the last fitted slot
module neo_slot_decode
   import neo_slot_pkg::*;
#(
   parameter int NUM_SLOTS = 6,
   parameter int SEL_W     = 3
) (
   input  logic [SEL_W-1:0]     slot_sel,
   input  logic                 enable,
   output logic [NUM_SLOTS-1:0] n_slot_cs,
   output logic                 slot_invalid
);

   // An out-of-range register value matches no index, so all selects stay high.
   always_comb begin
      n_slot_cs = '1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (enable && (slot_sel == SEL_W'(i))) n_slot_cs[i] = 1'b0;
      end
   end

   assign slot_invalid = (32'(slot_sel) >= NUM_SLOTS);

endmodule

// File: rtl/neo_slot_ctrl.sv
// Multi-slot cartridge controller: slot select register, slot decode and
// 68K DTACK / bus-error generation for ROM and port cycles.
// Ports:
//   CLK_68KCLK   in   block clock
//   nRESET       in   synchronous active-low reset
//   ENABLE       in   slot decode enable
//   nSLOTWR      in   slot register write strobe (falling edge loads SLOT_DIN)
//   SLOT_DIN     in   new slot number
//   nROMOE       in   ROM read strobe
//   nPORTCYC     in   port cycle strobe
//   nROMWAIT     in   per-slot ROM wait strap (0 = one wait state)
//   nPWAIT       in   per-slot {nPWAIT1,nPWAIT0} port wait straps
//   PDTACK       in   per-slot external acknowledge strap for port cycles
//   nEXTDTACK    in   external acknowledge from cartridge
//   nSLOTCS      out  one-hot active-low slot selects
//   SLOT_SEL     out  current slot register
//   SLOT_INVALID out  slot register >= NUM_SLOTS
//   nDTACK       out  acknowledge to 68K (registered)
//   nBERR        out  bus error to 68K (registered)
//
// state   | meaning
// IDLE    | no cycle in progress, watching for a strobe falling edge
// WAIT    | counting ROM/port wait states
// ACK     | nDTACK low until the active strobe releases
// EXT     | waiting for nEXTDTACK with a timeout running
// BERR    | nBERR low until the active strobe releases
module neo_slot_ctrl
   import neo_slot_pkg::*;
#(
   parameter int NUM_SLOTS = 6,
   parameter int SEL_W     = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic                   CLK_68KCLK,
   input  logic                   nRESET,
   input  logic                   ENABLE,
   input  logic                   nSLOTWR,
   input  logic [SEL_W-1:0]       SLOT_DIN,
   input  logic                   nROMOE,
   input  logic                   nPORTCYC,
   input  logic [NUM_SLOTS-1:0]   nROMWAIT,
   input  logic [2*NUM_SLOTS-1:0] nPWAIT,
   input  logic [NUM_SLOTS-1:0]   PDTACK,
   input  logic                   nEXTDTACK,
   output logic [NUM_SLOTS-1:0]   nSLOTCS,
   output logic [SEL_W-1:0]       SLOT_SEL,
   output logic                   SLOT_INVALID,
   output logic                   nDTACK,
   output logic                   nBERR
);

   logic [SEL_W-1:0] slot_q;
   logic             nslotwr_q, nromoe_q, nportcyc_q;
   logic             rom_fall_q, port_fall_q;
   state_t           state_q, state_d;
   logic             cyc_q, cyc_d;
   logic [1:0]       wcnt_q, wcnt_d;
   logic [7:0]       tcnt_q, tcnt_d;
   logic             ndtack_d, nberr_d;

   logic             s_romwait, s_pdtack;
   logic [1:0]       s_pwait, start_w, wcnt_dec;
   logic             strobe_hi;

   neo_slot_decode #(
      .NUM_SLOTS (NUM_SLOTS),
      .SEL_W     (SEL_W)
   ) u_decode (
      .slot_sel     (slot_q),
      .enable       (ENABLE),
      .n_slot_cs    (nSLOTCS),
      .slot_invalid (SLOT_INVALID)
   );

   assign SLOT_SEL = slot_q;

   // Straps of the selected slot; an invalid slot keeps the inactive
   // defaults, which yields zero waits and no external acknowledge.
   always_comb begin
      s_romwait = 1'b1;
      s_pwait   = 2'b11;
      s_pdtack  = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot_q == SEL_W'(i)) begin
            s_romwait = nROMWAIT[i];
            s_pwait   = nPWAIT[2*i +: 2];
            s_pdtack  = PDTACK[i];
         end
      end
   end

   assign start_w   = rom_fall_q ? {1'b0, ~s_romwait} : ~s_pwait;
   assign strobe_hi = (cyc_q == CYC_ROM) ? nROMOE : nPORTCYC;
   assign wcnt_dec  = wcnt_q - 2'd1;

   always_ff @(posedge CLK_68KCLK) begin
      if (!nRESET) begin
         slot_q      <= '0;
         nslotwr_q   <= 1'b1;
         nromoe_q    <= 1'b1;
         nportcyc_q  <= 1'b1;
         rom_fall_q  <= 1'b0;
         port_fall_q <= 1'b0;
         state_q     <= ST_IDLE;
         cyc_q       <= CYC_ROM;
         wcnt_q      <= '0;
         tcnt_q      <= '0;
         nDTACK      <= 1'b1;
         nBERR       <= 1'b1;
      end else begin
         nslotwr_q   <= nSLOTWR;
         nromoe_q    <= nROMOE;
         nportcyc_q  <= nPORTCYC;
         // Strobe falls are registered so a cycle starts one clock after
         // the edge, giving the 2 + W clock acknowledge latency.
         rom_fall_q  <= nromoe_q & ~nROMOE;
         port_fall_q <= nportcyc_q & ~nPORTCYC;
         if (nslotwr_q && !nSLOTWR) slot_q <= SLOT_DIN;
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         wcnt_q      <= wcnt_d;
         tcnt_q      <= tcnt_d;
         nDTACK      <= ndtack_d;
         nBERR       <= nberr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      wcnt_d  = wcnt_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rom_fall_q || port_fall_q) begin
               cyc_d = rom_fall_q ? CYC_ROM : CYC_PORT;
               if (!rom_fall_q && s_pdtack) begin
                  state_d = ST_EXT;
                  tcnt_d  = 8'(TIMEOUT - 1);
               end else if (start_w != 2'd0) begin
                  state_d = ST_WAIT;
                  wcnt_d  = start_w;
               end else begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_WAIT: begin
            if (strobe_hi) begin
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_dec;
               if (wcnt_dec == 2'd0) state_d = ST_ACK;
            end
         end
         ST_EXT: begin
            if (strobe_hi)           state_d = ST_IDLE;
            else if (!nEXTDTACK)     state_d = ST_ACK;
            else if (tcnt_q == 8'd0) state_d = ST_BERR;
            else                     tcnt_d  = tcnt_q - 8'd1;
         end
         ST_ACK, ST_BERR: begin
            if (strobe_hi) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ndtack_d = (state_d != ST_ACK);
      nberr_d  = (state_d != ST_BERR);
   end

endmodule

// File: doc/neo_slot_ctrl.md
Name: neo_slot_ctrl

Overview:
Parametrised multi-slot cartridge controller that generalises the single hard-wired slot to NUM_SLOTS slots. It holds the slot select register and decodes it to one-hot active-low slot selects. It also generates 68K DTACK for ROM and port cycles, using per-slot wait-state straps or external acknowledge, with a bus-error timeout. It sits between NEO-C1 strobe decode and the cartridge connectors, and replaces the fixed slot assignment at top level.

Parameters:
NUM_SLOTS, 6, number of cartridge slots (1..8)
SEL_W, 3, slot select register width; must satisfy 2^SEL_W >= NUM_SLOTS
TIMEOUT, 64, CLK_68KCLK cycles before nBERR in external-acknowledge mode (2..255)

Ports:
CLK_68KCLK  in  1  block clock; all state updates on its rising edge
nRESET  in  1  synchronous active-low reset
ENABLE  in  1  slot decode enable (SYSTEMB); when 0, all nSLOTCS are high
nSLOTWR  in  1  active-low slot register write strobe; a falling edge loads SLOT_DIN
SLOT_DIN  in  SEL_W  new slot number
nROMOE  in  1  active-low cartridge ROM read strobe (start of ROM cycle)
nPORTCYC  in  1  active-low port cycle (OR of port OE/WE strobes)
nROMWAIT  in  NUM_SLOTS  per-slot strap; 0 = ROM cycle takes 1 wait state
nPWAIT  in  2*NUM_SLOTS  per-slot {nPWAIT1,nPWAIT0} strap pairs, slot s at bits [2s+1:2s]
PDTACK  in  NUM_SLOTS  per-slot strap; 1 = port cycles use external acknowledge
nEXTDTACK  in  1  external acknowledge from cartridge, active low
nSLOTCS  out  NUM_SLOTS  one-hot active-low slot selects
SLOT_SEL  out  SEL_W  current slot register
SLOT_INVALID  out  1  register value >= NUM_SLOTS
nDTACK  out  1  active-low acknowledge to 68K
nBERR  out  1  active-low bus error

Behaviour:
- Reset (nRESET sampled low): slot register = 0; state = IDLE; nDTACK = 1; nBERR = 1; strobe edge registers = 1. nSLOTCS[0] = ~ENABLE and all other bits = 1.
- Slot register: falling edge of nSLOTWR is detected by a registered previous value, and SLOT_DIN loads on the next clock. nSLOTCS and SLOT_INVALID update from the register combinationally.
- Invalid slot: when the register is >= NUM_SLOTS, all nSLOTCS = 1 and SLOT_INVALID = 1.
- Cycle start:
  - A cycle starts in IDLE on a falling edge of nROMOE or nPORTCYC.
  - If both fall in the same clock, ROM takes priority.
  - At start, latch the cycle type and the selected slot's straps. A later slot write does not affect an in-flight cycle.
- Wait count W:
  - ROM cycle: W = ~nROMWAIT[s], giving 0 or 1.
  - Port cycle: W = {~nPWAIT1[s], ~nPWAIT0[s]}, giving 0..3.
  - Invalid slot: W = 0, straps ignored, external mode never used.
- States:
  - IDLE -> WAIT when W > 0. Load counter with W; counter decrements each clock.
  - IDLE -> ACK when W = 0 and not external mode. Counter 0 in WAIT -> ACK.
  - IDLE -> EXT for a port cycle with PDTACK[s] = 1. Timeout counter loads TIMEOUT-1.
  - EXT -> ACK when nEXTDTACK = 0. EXT -> BERR when the timeout counter reaches 0 with nEXTDTACK still 1.
  - ACK: nDTACK = 0. BERR: nBERR = 0.
  - ACK or BERR -> IDLE when the active strobe (nROMOE or nPORTCYC, per latched type) returns high. Outputs deassert on that same clock edge.
  - Strobe released early in WAIT or EXT: abort to IDLE with no acknowledge.
- Latency, strobe fall to nDTACK low: 1 clock (edge detect) + W clocks + 1 clock. W = 0 gives 2 clocks.
- nDTACK and nBERR are registered outputs and are never low together.
- Reset mid-cycle: return to IDLE and deassert nDTACK and nBERR on that edge.

Decomposition:
- Shared package neo_slot_pkg holds:
  - state encoding constants ST_IDLE, ST_WAIT, ST_ACK, ST_EXT, ST_BERR
  - cycle type constants CYC_ROM, CYC_PORT
- One natural sub-module, neo_slot_decode: purely combinational. It maps register, ENABLE and NUM_SLOTS to nSLOTCS and SLOT_INVALID.
- The FSM and the wait and timeout counters stay in neo_slot_ctrl.

Test Plan:
- Reset then ENABLE=1, NUM_SLOTS=6 -> nSLOTCS=6'b111110, SLOT_SEL=0, nDTACK=1, nBERR=1.
- nSLOTWR pulse with SLOT_DIN=3 -> next clock nSLOTCS=6'b110111. Then SLOT_DIN=7 -> nSLOTCS=6'b111111, SLOT_INVALID=1. Then ENABLE=0 with slot 3 -> all high.
- Slot 2, nROMWAIT[2]=0, nROMOE falls -> nDTACK low 3 clocks after the edge, stays low until nROMOE rises, high on the following clock. With nROMWAIT[2]=1 -> 2 clocks.
- Slot 1, nPWAIT pair 2'b00 (3 waits), nPORTCYC falls -> nDTACK low after 5 clocks. A slot write to 4 mid-cycle does not change latency.
- Slot 0, PDTACK[0]=1, nEXTDTACK low 10 clocks after start -> nDTACK low 1 clock later. nEXTDTACK never low, TIMEOUT=64 -> nBERR low, nDTACK stays 1.
- nROMOE and nPORTCYC fall together -> ROM wait straps used. nRESET low during WAIT -> IDLE next edge, no acknowledge issued.
